// File: rtl/game_step_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// game_step_ctrl_pkg
// Shared types for the snake game step sequencer.
//   mode_t       : game mode as decoded by the menu logic
//   result_t     : match outcome reported to the score/menu logic
//   step_state_t : sequencer states
//   DIR_TIMEOUT_DEF / STEP_TO_DEF : default timeout lengths in clk cycles
//   verdict()    : folds the collision flags into a single result_t
// ----------------------------------------------------------------------------
package game_step_ctrl_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        GAME  = 2'd1,
        PAUSE = 2'd2,
        SCORE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        WON  = 2'd1,
        LOST = 2'd2,
        DRAW = 2'd3
    } result_t;

    typedef enum logic [2:0] {
        WAIT_TICK = 3'd0,
        WAIT_DIR  = 3'd1,
        MOVE      = 3'd2,
        COLLIDE   = 3'd3,
        POINT     = 3'd4,
        OVER      = 3'd5,
        HALT      = 3'd6
    } step_state_t;

    localparam int DIR_TIMEOUT_DEF = 1500;
    localparam int STEP_TO_DEF     = 4096;

    // Both snakes dying in the same step is a draw, and an explicit draw
    // flag overrides any single-player verdict.
    function automatic result_t verdict(input logic won, input logic lost,
                                        input logic draw);
        result_t r;
        if (draw || (won && lost)) r = DRAW;
        else if (won)              r = WON;
        else if (lost)             r = LOST;
        else                       r = NONE;
        return r;
    endfunction

endpackage

// File: rtl/game_step_ctrl_if.sv
// ----------------------------------------------------------------------------
// game_step_ctrl_if
// Start/done handshake between the step sequencer and the datapath blocks
// (move, collisions, generate_point).
//   move_start / refreshed, eaten1, eaten2        : move block
//   coll_start / coll_done, won, lost, draw       : collision block
//   point_start / point_rdy                       : point generator
// master = sequencer side, slave = datapath side.
// ----------------------------------------------------------------------------
interface game_step_ctrl_if;

    logic move_start;
    logic coll_start;
    logic point_start;
    logic refreshed;
    logic eaten1;
    logic eaten2;
    logic coll_done;
    logic won;
    logic lost;
    logic draw;
    logic point_rdy;

    modport master (
        output move_start, coll_start, point_start,
        input  refreshed, eaten1, eaten2, coll_done, won, lost, draw, point_rdy
    );

    modport slave (
        input  move_start, coll_start, point_start,
        output refreshed, eaten1, eaten2, coll_done, won, lost, draw, point_rdy
    );

endinterface

// File: rtl/game_step_ctrl_step_watchdog.sv
// ----------------------------------------------------------------------------
// step_watchdog
// Cycle counter with synchronous clear and a terminal-count strobe.
//   clk, rst  : clock, asynchronous active-low reset
//   clr_i     : forces the count to zero on the next edge
//   en_i      : counts one cycle per clock while high
//   tc_o      : high while enabled and the count equals LIMIT-1
// The count holds at LIMIT-1; the owner is expected to leave the state
// that enables it on the strobe.
// ----------------------------------------------------------------------------
module step_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                  cnt_d = '0;
        else if (en_i && !tc_o)     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_step_ctrl.sv
// ----------------------------------------------------------------------------
// game_step_ctrl
// Per-tick sequencer for the snake game datapath. One game step collects
// both player directions, runs move, runs the collision check and, if a
// point was eaten, regenerates the point.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   mode       in   game mode; stepping only while mode == GAME
//   tick       in   one-cycle step strobe from clk_div
//   rcvdir1/2  in   one-cycle strobes: direction received for player 1/2
//   dp         master side of game_step_ctrl_if (start/done handshakes)
//   step_done  out  one-cycle strobe, step complete and game continues
//   result     out  NONE/WON/LOST/DRAW, held until reset or mode exit
//   com_err    out  one-cycle strobe, stepped with previous directions
//   stall_err  out  sticky, a datapath stage timed out
//   overrun    out  one-cycle strobe, tick arrived mid-step and was dropped
//   step_cnt   out  completed steps
//
// Build option: define GAME_STEP_STATS_EN to get a live step counter;
// without it step_cnt is constant zero.
// ----------------------------------------------------------------------------
module game_step_ctrl
    import game_step_ctrl_pkg::*;
#(
    parameter int DIR_TIMEOUT = DIR_TIMEOUT_DEF,
    parameter int STEP_TO     = STEP_TO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  mode_t              mode,
    input  logic               tick,
    input  logic               rcvdir1,
    input  logic               rcvdir2,
    game_step_ctrl_if.master   dp,
    output logic               step_done,
    output result_t            result,
    output logic               com_err,
    output logic               stall_err,
    output logic               overrun,
    output logic [15:0]        step_cnt
);

    step_state_t state_q, state_d;
    logic        dir1_q, dir1_d;
    logic        dir2_q, dir2_d;
    logic        eaten_q, eaten_d;
    logic        move_start_q, move_start_d;
    logic        coll_start_q, coll_start_d;
    logic        point_start_q, point_start_d;
    logic        step_done_q, step_done_d;
    result_t     result_q, result_d;
    logic        com_err_q, com_err_d;
    logic        stall_err_q, stall_err_d;
    logic        overrun_q, overrun_d;

    logic in_game;
    logic have1, have2;
    logic stage_st;
    logic dir_tc, stg_tc;
    logic dir_clr, dir_en, stg_clr, stg_en;

    assign in_game  = (mode == GAME);
    // A direction arriving this very cycle counts as already collected.
    assign have1    = dir1_q | rcvdir1;
    assign have2    = dir2_q | rcvdir2;
    assign stage_st = (state_q == MOVE) || (state_q == COLLIDE) || (state_q == POINT);

    // Direction timer runs only while waiting for directions and is zero on entry.
    assign dir_clr = (state_q != WAIT_DIR);
    assign dir_en  = in_game && (state_q == WAIT_DIR);

    // Stage timer restarts with every start strobe so each stage gets a full budget.
    assign stg_clr = move_start_d || coll_start_d || point_start_d || !stage_st;
    assign stg_en  = in_game && stage_st;

    step_watchdog #(.LIMIT(DIR_TIMEOUT)) u_dir_wd (
        .clk   (clk),
        .rst   (rst),
        .clr_i (dir_clr),
        .en_i  (dir_en),
        .tc_o  (dir_tc)
    );

    step_watchdog #(.LIMIT(STEP_TO)) u_stage_wd (
        .clk   (clk),
        .rst   (rst),
        .clr_i (stg_clr),
        .en_i  (stg_en),
        .tc_o  (stg_tc)
    );

    always_comb begin
        state_d       = state_q;
        dir1_d        = have1;
        dir2_d        = have2;
        eaten_d       = eaten_q;
        move_start_d  = 1'b0;
        coll_start_d  = 1'b0;
        point_start_d = 1'b0;
        step_done_d   = 1'b0;
        result_d      = result_q;
        com_err_d     = 1'b0;
        stall_err_d   = stall_err_q;
        overrun_d     = 1'b0;

        if (!in_game) begin
            // Leaving GAME abandons the step; late done strobes fall into WAIT_TICK and are ignored.
            state_d     = WAIT_TICK;
            dir1_d      = 1'b0;
            dir2_d      = 1'b0;
            eaten_d     = 1'b0;
            result_d    = NONE;
            stall_err_d = 1'b0;
        end else begin
            if (tick && (state_q == WAIT_DIR || stage_st)) overrun_d = 1'b1;

            unique case (state_q)
                WAIT_TICK: begin
                    if (tick) begin
                        // Directions collected ahead of the tick let the move start right away.
                        if (have1 && have2) begin
                            move_start_d = 1'b1;
                            dir1_d       = 1'b0;
                            dir2_d       = 1'b0;
                            state_d      = MOVE;
                        end else begin
                            state_d = WAIT_DIR;
                        end
                    end
                end
                WAIT_DIR: begin
                    if ((have1 && have2) || dir_tc) begin
                        move_start_d = 1'b1;
                        com_err_d    = !(have1 && have2);
                        dir1_d       = 1'b0;
                        dir2_d       = 1'b0;
                        state_d      = MOVE;
                    end
                end
                MOVE: begin
                    if (dp.refreshed) begin
                        eaten_d      = dp.eaten1 | dp.eaten2;
                        coll_start_d = 1'b1;
                        state_d      = COLLIDE;
                    end else if (stg_tc) begin
                        stall_err_d = 1'b1;
                        state_d     = HALT;
                    end
                end
                COLLIDE: begin
                    if (dp.coll_done) begin
                        if (dp.won || dp.lost || dp.draw) begin
                            result_d = verdict(dp.won, dp.lost, dp.draw);
                            state_d  = OVER;
                        end else if (eaten_q) begin
                            point_start_d = 1'b1;
                            state_d       = POINT;
                        end else begin
                            step_done_d = 1'b1;
                            state_d     = WAIT_TICK;
                        end
                    end else if (stg_tc) begin
                        stall_err_d = 1'b1;
                        state_d     = HALT;
                    end
                end
                POINT: begin
                    if (dp.point_rdy) begin
                        step_done_d = 1'b1;
                        state_d     = WAIT_TICK;
                    end else if (stg_tc) begin
                        stall_err_d = 1'b1;
                        state_d     = HALT;
                    end
                end
                OVER, HALT: begin
                    // Parked until the menu takes the game out of GAME.
                end
                default: state_d = WAIT_TICK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= WAIT_TICK;
            dir1_q        <= 1'b0;
            dir2_q        <= 1'b0;
            eaten_q       <= 1'b0;
            move_start_q  <= 1'b0;
            coll_start_q  <= 1'b0;
            point_start_q <= 1'b0;
            step_done_q   <= 1'b0;
            result_q      <= NONE;
            com_err_q     <= 1'b0;
            stall_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir1_q        <= dir1_d;
            dir2_q        <= dir2_d;
            eaten_q       <= eaten_d;
            move_start_q  <= move_start_d;
            coll_start_q  <= coll_start_d;
            point_start_q <= point_start_d;
            step_done_q   <= step_done_d;
            result_q      <= result_d;
            com_err_q     <= com_err_d;
            stall_err_q   <= stall_err_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef GAME_STEP_STATS_EN
    logic [15:0] step_cnt_q, step_cnt_d;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (!in_game)         step_cnt_d = 16'd0;
        else if (step_done_d) step_cnt_d = step_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) step_cnt_q <= 16'd0;
        else      step_cnt_q <= step_cnt_d;
    end

    assign step_cnt = step_cnt_q;
`else
    assign step_cnt = 16'd0;
`endif

    assign dp.move_start  = move_start_q;
    assign dp.coll_start  = coll_start_q;
    assign dp.point_start = point_start_q;
    assign step_done      = step_done_q;
    assign result         = result_q;
    assign com_err        = com_err_q;
    assign stall_err      = stall_err_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_game_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_game_step_ctrl
// Directed bench for game_step_ctrl. A step-level model of the game rules
// predicts every output each cycle; literal expectations at key instants
// tie both the DUT and the model to hand-worked cycle counts.
// ----------------------------------------------------------------------------
module tb_game_step_ctrl;
    import game_step_ctrl_pkg::*;

    localparam int DIR_TO = 1500;
    localparam int STP_TO = 4096;

    localparam logic [10:0] TK = 11'h001;
    localparam logic [10:0] R1 = 11'h002;
    localparam logic [10:0] R2 = 11'h004;
    localparam logic [10:0] RF = 11'h008;
    localparam logic [10:0] E1 = 11'h010;
    localparam logic [10:0] E2 = 11'h020;
    localparam logic [10:0] CD = 11'h040;
    localparam logic [10:0] WN = 11'h080;
    localparam logic [10:0] LS = 11'h100;
    localparam logic [10:0] DR = 11'h200;
    localparam logic [10:0] PR = 11'h400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mode_t       mode = MENU;
    logic        tick = 1'b0;
    logic        rcvdir1 = 1'b0;
    logic        rcvdir2 = 1'b0;
    logic        step_done, com_err, stall_err, overrun;
    result_t     result;
    logic [15:0] step_cnt;

    int errors = 0;
    int checks = 0;

    game_step_ctrl_if dp();

    game_step_ctrl #(.DIR_TIMEOUT(DIR_TO), .STEP_TO(STP_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .tick      (tick),
        .rcvdir1   (rcvdir1),
        .rcvdir2   (rcvdir2),
        .dp        (dp),
        .step_done (step_done),
        .result    (result),
        .com_err   (com_err),
        .stall_err (stall_err),
        .overrun   (overrun),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- step-level reference model ----------------
    localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_MOVING = 2, PH_CHECKING = 3,
                   PH_PLACING = 4, PH_ENDED = 5, PH_HALTED = 6;

    int      ph = PH_IDLE;
    int      age = 0;
    bit      pend1 = 0, pend2 = 0, ate = 0;
    bit      e_move = 0, e_coll = 0, e_point = 0, e_done = 0, e_com = 0, e_stall = 0, e_ovr = 0;
    result_t e_res = NONE;
    int      e_cnt = 0;

    task automatic m_launch(input bit timed_out);
        e_move = 1; e_com = timed_out; pend1 = 0; pend2 = 0; ph = PH_MOVING; age = 0;
    endtask

    task automatic m_complete();
        e_done = 1; ph = PH_IDLE;
`ifdef GAME_STEP_STATS_EN
        e_cnt = (e_cnt + 1) % 65536;
`endif
    endtask

    task automatic m_age_stage();
        if (age == STP_TO - 1) begin e_stall = 1; ph = PH_HALTED; end
        else age++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            e_move = 0; e_coll = 0; e_point = 0; e_done = 0; e_com = 0; e_ovr = 0;
            if (!rst) begin
                ph = PH_IDLE; age = 0; pend1 = 0; pend2 = 0; ate = 0;
                e_stall = 0; e_res = NONE; e_cnt = 0;
            end else if (mode != GAME) begin
                ph = PH_IDLE; pend1 = 0; pend2 = 0; ate = 0;
                e_stall = 0; e_res = NONE; e_cnt = 0;
            end else begin
                pend1 = pend1 | rcvdir1;
                pend2 = pend2 | rcvdir2;
                if (tick && ph >= PH_COLLECT && ph <= PH_PLACING) e_ovr = 1;
                case (ph)
                    PH_IDLE:
                        if (tick) begin
                            if (pend1 && pend2) m_launch(0);
                            else begin ph = PH_COLLECT; age = 0; end
                        end
                    PH_COLLECT:
                        if (pend1 && pend2)          m_launch(0);
                        else if (age == DIR_TO - 1)  m_launch(1);
                        else                         age++;
                    PH_MOVING:
                        if (dp.refreshed) begin
                            ate = dp.eaten1 | dp.eaten2; e_coll = 1; ph = PH_CHECKING; age = 0;
                        end else m_age_stage();
                    PH_CHECKING:
                        if (dp.coll_done) begin
                            if (dp.draw || (dp.won && dp.lost)) begin e_res = DRAW; ph = PH_ENDED; end
                            else if (dp.won)  begin e_res = WON;  ph = PH_ENDED; end
                            else if (dp.lost) begin e_res = LOST; ph = PH_ENDED; end
                            else if (ate)     begin e_point = 1; ph = PH_PLACING; age = 0; end
                            else m_complete();
                        end else m_age_stage();
                    PH_PLACING:
                        if (dp.point_rdy) m_complete();
                        else m_age_stage();
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("move_start",  dp.move_start,  e_move);
                chk("coll_start",  dp.coll_start,  e_coll);
                chk("point_start", dp.point_start, e_point);
                chk("step_done",   step_done,      e_done);
                chk("result",      result,         e_res);
                chk("com_err",     com_err,        e_com);
                chk("stall_err",   stall_err,      e_stall);
                chk("overrun",     overrun,        e_ovr);
                chk("step_cnt",    step_cnt,       e_cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [10:0] v);
        @(negedge clk);
        {dp.point_rdy, dp.draw, dp.lost, dp.won, dp.coll_done, dp.eaten2, dp.eaten1,
         dp.refreshed, rcvdir2, rcvdir1, tick} = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(11'h000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        {dp.point_rdy, dp.draw, dp.lost, dp.won, dp.coll_done, dp.eaten2, dp.eaten1,
         dp.refreshed} = '0;
        mode = GAME;
        repeat (2) @(negedge clk);
        chk("rst_move",   dp.move_start, 0);
        chk("rst_result", result, NONE);
        chk("rst_stall",  stall_err, 0);
        chk("rst_cnt",    step_cnt, 0);
        @(negedge clk); #2 rst = 1'b1;

        // 1: split direction arrival, clean step
        drive(TK); drive(0); drive(R1); drive(0); drive(R2);
        chk("t1_move_early", dp.move_start, 0);
        drive(0);
        chk("t1_move", dp.move_start, 1);
        chk("t1_model_move", e_move, 1);
        drive(0); drive(RF); drive(0);
        chk("t1_coll", dp.coll_start, 1);
        drive(CD); drive(0);
        chk("t1_done", step_done, 1);
        chk("t1_nopoint", dp.point_start, 0);

        // 2: directions before tick, point eaten -> regenerate
        mode = MENU; drive(0); mode = GAME;
        drive(R1); drive(R2); drive(TK); drive(0);
        chk("t2_move_fast", dp.move_start, 1);
        drive(RF | E1); drive(0);
        chk("t2_coll", dp.coll_start, 1);
        drive(CD); drive(0);
        chk("t2_point", dp.point_start, 1);
        chk("t2_nodone", step_done, 0);
        drive(PR); drive(0);
        chk("t2_done", step_done, 1);
`ifdef GAME_STEP_STATS_EN
        chk("t2_cnt", step_cnt, 1);
`else
        chk("t2_cnt", step_cnt, 0);
`endif

        // 3: only player 1 sends -> timeout
        drive(TK); drive(R1);
        idle(DIR_TO - 1);
        chk("t3_move_early", dp.move_start, 0);
        drive(0);
        chk("t3_move", dp.move_start, 1);
        chk("t3_comerr", com_err, 1);
        chk("t3_model_com", e_com, 1);
        drive(RF); drive(CD); drive(0);
        chk("t3_done", step_done, 1);

        // 4: both lose -> draw, game parked
        drive(TK); drive(R1 | R2); drive(0);
        drive(RF); drive(CD | WN | LS); drive(0);
        chk("t4_draw", result, DRAW);
        chk("t4_model_draw", e_res, DRAW);
        for (int i = 0; i < 3; i++) begin
            drive(TK); drive(R1 | R2);
            chk("t4_nomove", dp.move_start, 0);
            chk("t4_noovr", overrun, 0);
        end
        mode = MENU; drive(0);
        chk("t4_menu_res", result, NONE);
        mode = GAME;

        // 5: overrun during MOVE, then stage stall
        drive(TK); drive(R1 | R2); drive(0);
        chk("t5_move", dp.move_start, 1);
        drive(TK); drive(0);
        chk("t5_ovr", overrun, 1);
        drive(RF); drive(CD); drive(0);
        chk("t5_done", step_done, 1);
        drive(TK); drive(R1 | R2); drive(0);
        chk("t5_move2", dp.move_start, 1);
        idle(STP_TO - 1);
        chk("t5_stall_early", stall_err, 0);
        drive(0);
        chk("t5_stall", stall_err, 1);
        drive(TK); drive(0);
        chk("t5_halt_noovr", overrun, 0);
        chk("t5_stall_held", stall_err, 1);
        mode = MENU; drive(0);
        chk("t5_stall_clr", stall_err, 0);
        mode = GAME;

        // 6: reset in the middle of COLLIDE
        drive(TK); drive(R1 | R2); drive(RF); drive(0);
        chk("t6_coll", dp.coll_start, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_coll", dp.coll_start, 0);
        chk("t6_rst_res", result, NONE);
        chk("t6_rst_done", step_done, 0);
        @(negedge clk); #2 rst = 1'b1;
        drive(CD | WN); drive(0);
        chk("t6_late_res", result, NONE);
        chk("t6_late_done", step_done, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
